alu_issue_ctrl: RTL and testbench

- Initiator side of the 4-bit ALU operand interface.
- Accepts operation commands over a valid/ready handshake and drives the combinational alu_4bit datapath one nibble per cycle.
- Chains the carry across passes so one command can be a 4-bit (narrow) or 8-bit (wide) operation.
- Captures z/cout and returns a response over a valid/ready handshake; sits between the instruction/control logic and the ALU.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_issue_ctrl_if.sv | 46 ++++
 rtl/alu_4bit.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 114 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU issue path.
//   - NIB      : ALU slice width (fixed at 4)
//   - alu_op_e : ALU operation encodings as seen on s_op
//   - state_e  : issue controller FSM states
package alu_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    OP_NAND = 2'b00,
    OP_NOR  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    RESP
  } state_e;

  // ADD and SUB are the only ops whose carry means anything.
  function automatic logic is_arith(alu_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the issue controller's handshake and ALU-operand signals.
//   cmd_* : command channel (valid/ready), operands are 4*NPASS bits
//   alu_* : nibble-wide operand bus to the combinational alu_4bit
//   rsp_* : response channel (valid/ready)
// modport master : the controller's view (drives cmd_ready, alu_*, rsp_*)
// modport slave  : the surrounding logic's view (drives cmd_*, alu_z/cout, rsp_ready)
interface alu_issue_ctrl_if #(
  parameter int NPASS = 2
);
  import alu_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic                   cmd_wide;
  logic [NIB*NPASS-1:0]   cmd_a;
  logic [NIB*NPASS-1:0]   cmd_b;
  logic                   cmd_cin;

  logic [NIB-1:0]         alu_a;
  logic [NIB-1:0]         alu_b;
  logic                   alu_cin;
  logic [1:0]             alu_s_op;
  logic [NIB-1:0]         alu_z;
  logic                   alu_cout;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [NIB*NPASS-1:0]   rsp_z;
  logic                   rsp_cout;

  modport master (
    input  cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b, cmd_cin,
    input  alu_z, alu_cout, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_cin, alu_s_op,
    output rsp_valid, rsp_z, rsp_cout
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b, cmd_cin,
    output alu_z, alu_cout, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_cin, alu_s_op,
    input  rsp_valid, rsp_z, rsp_cout
  );

endinterface

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU slice driven by alu_issue_ctrl.
//   a, b, cin, s_op : operands and op select (NAND, NOR, ADD, SUB)
//   z, cout         : result nibble and carry-out (0 for logic ops)
// SUB computes a + ~b + cin, so the caller supplies cin=1 for a true subtract.
module alu_4bit
  import alu_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  input  logic [1:0]     s_op,
  output logic [NIB-1:0] z,
  output logic           cout
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would infer a latch.
    z    = '0;
    cout = 1'b0;
    unique case (alu_op_e'(s_op))
      OP_NAND: z = ~(a & b);
      OP_NOR:  z = ~(a | b);
      OP_ADD:  {cout, z} = {1'b0, a} + {1'b0, b} + {{NIB{1'b0}}, cin};
      OP_SUB:  {cout, z} = {1'b0, a} + {1'b0, ~b} + {{NIB{1'b0}}, cin};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the 4-bit ALU operand interface.
// Accepts a command, walks the operands through the ALU one nibble per cycle
// (chaining the carry for ADD/SUB), collects the result and returns it on the
// response channel. One command outstanding at a time.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset; aborts any command in flight
//   bus   : alu_issue_ctrl_if.master (cmd_*, alu_*, rsp_*)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NPASS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.master  bus
);

  localparam int                CNT_W     = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [CNT_W-1:0]  LAST_PASS = CNT_W'(NPASS - 1);

  state_e                     state, state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_inc;
  alu_op_e                    op_q;
  logic                       wide_q;
  logic [NPASS-1:0][NIB-1:0]  a_q, b_q, res_q;
  logic                       more_passes;

  assign cnt_inc     = cnt + CNT_W'(1);
  assign more_passes = wide_q && (cnt != LAST_PASS);
  assign bus.rsp_z   = res_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = PASS;
      end
      PASS: begin
        if (!more_passes) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. alu_* are registered, so the ALU result for the nibble driven
  // at one edge is sampled at the next edge while in PASS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the result/operand stores are a handful of flops, not a RAM,
      // so they are reset; rsp_z must read 0 out of reset.
      cnt          <= '0;
      op_q         <= OP_NAND;
      wide_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_cin  <= 1'b0;
      bus.alu_s_op <= '0;
      bus.rsp_cout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q         <= alu_op_e'(bus.cmd_op);
            wide_q       <= bus.cmd_wide;
            a_q          <= bus.cmd_a;
            b_q          <= bus.cmd_b;
            res_q        <= '0;  // narrow results leave the upper nibbles at 0
            cnt          <= '0;
            bus.alu_a    <= bus.cmd_a[NIB-1:0];
            bus.alu_b    <= bus.cmd_b[NIB-1:0];
            bus.alu_s_op <= bus.cmd_op;
            unique case (alu_op_e'(bus.cmd_op))
              OP_ADD:  bus.alu_cin <= bus.cmd_cin;
              OP_SUB:  bus.alu_cin <= 1'b1;  // a + ~b + 1 = a - b
              default: bus.alu_cin <= 1'b0;
            endcase
          end
        end
        PASS: begin
          res_q[cnt] <= bus.alu_z;
          if (more_passes) begin
            cnt         <= cnt_inc;
            bus.alu_a   <= a_q[cnt_inc];
            bus.alu_b   <= b_q[cnt_inc];
            // alu_cin doubles as the chain-carry register between passes.
            bus.alu_cin <= is_arith(op_q) ? bus.alu_cout : 1'b0;
          end else begin
            bus.rsp_cout <= is_arith(op_q) ? bus.alu_cout : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with alu_4bit wired beside it.
// Expected results come from a whole-word arithmetic reference model.
module tb_alu_issue_ctrl;
  localparam int NPASS = 2;
  localparam int W     = 4 * NPASS;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  alu_issue_ctrl_if #(.NPASS(NPASS)) bus ();

  alu_4bit u_alu (
    .a    (bus.alu_a),
    .b    (bus.alu_b),
    .cin  (bus.alu_cin),
    .s_op (bus.alu_s_op),
    .z    (bus.alu_z),
    .cout (bus.alu_cout)
  );

  alu_issue_ctrl #(.NPASS(NPASS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word model: operate on the low 4 or 8 bits as plain integers.
  function automatic void ref_model(input logic [1:0] op, input logic wide,
                                    input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin,
                                    output logic [W-1:0] z, output logic cout);
    int w, mask, am, bm, r;
    w    = wide ? W : 4;
    mask = (1 << w) - 1;
    am   = int'(a) & mask;
    bm   = int'(b) & mask;
    r    = 0;
    cout = 1'b0;
    case (op)
      2'b00: r = ~(am & bm) & mask;
      2'b01: r = ~(am | bm) & mask;
      2'b10: begin
        r    = am + bm + (cin ? 1 : 0);
        cout = ((r >> w) & 1) != 0;
        r    = r & mask;
      end
      default: begin
        cout = (am >= bm);
        r    = (am - bm) & mask;
      end
    endcase
    z = W'(r);
  endfunction

  // Issue one command from a negedge and follow it to the handshake.
  // hold: cycles rsp_ready stays low in RESP. pend: keep cmd_valid high
  // through RESP, as a queued follow-on command would.
  task automatic run_cmd(input logic [1:0] op, input logic wide,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input int hold, input logic pend,
                         output logic [W-1:0] z_o, output logic cout_o,
                         output int lat_o);
    logic [W-1:0] ez;
    logic         ec;
    int           lat;
    ref_model(op, wide, a, b, cin, ez, ec);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_wide  = wide;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_cin   = cin;
    bus.rsp_ready = (hold == 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // cmd_valid stays high through PASS; it must be ignored there.
    while (!bus.rsp_valid && lat < 16) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), wide ? 32'(NPASS + 1) : 32'd2);
    check("rsp_z", 32'(bus.rsp_z), 32'(ez));
    check("rsp_cout", 32'(bus.rsp_cout), 32'(ec));
    check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    z_o    = bus.rsp_z;
    cout_o = bus.rsp_cout;
    lat_o  = lat;
    bus.cmd_valid = pend;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_z", 32'(bus.rsp_z), 32'(ez));
      check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_hs_idle", 32'(bus.cmd_ready), 32'd1);
    bus.rsp_ready = 1'b0;
    if (!pend) bus.cmd_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] z;
    logic         c;
    int           lat;
    total         = 0;
    passed        = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_wide  = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_z", 32'(bus.rsp_z), 32'd0);
    check("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_cin", 32'(bus.alu_cin), 32'd0);
    check("rst_alu_s_op", 32'(bus.alu_s_op), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with literal expectations.
    run_cmd(2'b10, 1'b1, 8'h7F, 8'h01, 1'b0, 0, 1'b0, z, c, lat);
    check("add_7f_z", 32'(z), 32'h80);
    check("add_7f_c", 32'(c), 32'd0);
    check("add_7f_lat", 32'(lat), 32'd3);
    run_cmd(2'b10, 1'b1, 8'hFF, 8'h01, 1'b0, 0, 1'b0, z, c, lat);
    check("add_ff_z", 32'(z), 32'h00);
    check("add_ff_c", 32'(c), 32'd1);
    run_cmd(2'b11, 1'b1, 8'h10, 8'h01, 1'b0, 0, 1'b0, z, c, lat);
    check("sub_10_z", 32'(z), 32'h0F);
    check("sub_10_c", 32'(c), 32'd1);
    run_cmd(2'b11, 1'b1, 8'h01, 8'h02, 1'b1, 0, 1'b0, z, c, lat);
    check("sub_01_z", 32'(z), 32'hFF);
    check("sub_01_c", 32'(c), 32'd0);
    run_cmd(2'b00, 1'b0, 8'hF0, 8'hCC, 1'b1, 0, 1'b0, z, c, lat);
    check("nand_z", 32'(z), 32'h0F);
    check("nand_c", 32'(c), 32'd0);
    check("nand_lat", 32'(lat), 32'd2);
    run_cmd(2'b01, 1'b1, 8'hF0, 8'h0C, 1'b0, 0, 1'b0, z, c, lat);
    check("nor_z", 32'(z), 32'h03);
    run_cmd(2'b10, 1'b0, 8'hA9, 8'h38, 1'b1, 0, 1'b0, z, c, lat);
    check("add_narrow_z", 32'(z), 32'h02);
    check("add_narrow_c", 32'(c), 32'd1);

    // Backpressure with a follow-on command waiting, then that command.
    run_cmd(2'b10, 1'b1, 8'h3C, 8'h5A, 1'b1, 5, 1'b1, z, c, lat);
    check("bp_z", 32'(z), 32'h97);
    run_cmd(2'b10, 1'b1, 8'h3C, 8'h5A, 1'b1, 0, 1'b0, z, c, lat);
    check("b2b_z", 32'(z), 32'h97);

    // Randomized commands against the model.
    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), z, c, lat);
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);

    // Reset during the PASS of a wide ADD: command aborted, no response.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_wide  = 1'b1;
    bus.cmd_a     = 8'hFF;
    bus.cmd_b     = 8'h01;
    bus.cmd_cin   = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_rsp_z", 32'(bus.rsp_z), 32'd0);
    check("abort_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    run_cmd(2'b11, 1'b1, 8'h80, 8'h81, 1'b0, 1, 1'b0, z, c, lat);
    check("recover_z", 32'(z), 32'hFF);
    check("recover_c", 32'(c), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
